// File: rtl/pc_gen_pkg.sv
// Shared core definitions: FSM state encoding and default PC-generator geometry.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } pc_state_e;

    localparam int          DEF_XLEN         = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam int          DEF_STEP         = 4;
    localparam int          DEF_ALIGN_BITS   = 2;

endpackage

// File: rtl/pc_target_check.sv
// Alignment check for a control-flow target: flags nonzero low bits and
// provides the target with those bits cleared.
module pc_target_check #(
    parameter int XLEN       = 32,
    parameter int ALIGN_BITS = 2
) (
    input  logic [XLEN-1:0] target,
    output logic            misaligned,
    output logic [XLEN-1:0] aligned
);

    assign misaligned = |target[ALIGN_BITS-1:0];
    assign aligned    = {target[XLEN-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch with valid/ready handshake,
// trap/redirect arbitration, misaligned-target fault and halt/resume.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               XLEN         = DEF_XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter int               STEP         = DEF_STEP,
    parameter int               ALIGN_BITS   = DEF_ALIGN_BITS
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt_req,
    input  logic            resume,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] current_pc,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_pc,
    output logic [1:0]      state
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] misalign_pc_q, misalign_pc_d;
    logic            fetch_valid_q, fetch_valid_d;

    logic            redir_misaligned;
    logic [XLEN-1:0] redir_aligned;
    logic            trap_lowbits_unused;
    logic [XLEN-1:0] trap_aligned;
    logic [XLEN-1:0] pc_inc;
    logic            accepted;

    pc_target_check #(.XLEN(XLEN), .ALIGN_BITS(ALIGN_BITS)) u_redir_chk (
        .target     (redirect_target),
        .misaligned (redir_misaligned),
        .aligned    (redir_aligned)
    );

    // Trap vectors are masked rather than checked, so they never fault.
    pc_target_check #(.XLEN(XLEN), .ALIGN_BITS(ALIGN_BITS)) u_trap_chk (
        .target     (trap_vector),
        .misaligned (trap_lowbits_unused),
        .aligned    (trap_aligned)
    );

    assign pc_inc   = pc_q + XLEN'(STEP);
    assign accepted = fetch_valid_q && fetch_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        misalign_pc_d = misalign_pc_q;
        fetch_valid_d = fetch_valid_q;
        if (en) begin
            case (state_q)
                ST_BOOT: begin
                    state_d       = ST_RUN;
                    fetch_valid_d = 1'b1;
                end
                ST_RUN: begin
                    if (trap_valid) begin
                        pc_d          = trap_aligned;
                        fetch_valid_d = 1'b1;
                    end else if (redirect_valid && redir_misaligned) begin
                        state_d       = ST_FAULT;
                        misalign_pc_d = redirect_target;
                        fetch_valid_d = 1'b0;
                    end else if (redirect_valid) begin
                        pc_d          = redir_aligned;
                        fetch_valid_d = 1'b1;
                    end else if (halt_req) begin
                        // An accepted request completes before halting; a pending one is dropped.
                        if (accepted) pc_d = pc_inc;
                        state_d       = ST_HALT;
                        fetch_valid_d = 1'b0;
                    end else if (accepted) begin
                        pc_d = pc_inc;
                    end
                end
                ST_HALT: begin
                    if (trap_valid) begin
                        state_d       = ST_RUN;
                        pc_d          = trap_aligned;
                        fetch_valid_d = 1'b1;
                    end else if (resume) begin
                        state_d       = ST_RUN;
                        fetch_valid_d = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (trap_valid) begin
                        state_d       = ST_RUN;
                        pc_d          = trap_aligned;
                        fetch_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d       = ST_BOOT;
                    fetch_valid_d = 1'b0;
                end
            endcase
        end
    end

    // The core updates all state on the falling edge.
    always_ff @(negedge sys_clk) begin
        if (!sys_rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            misalign_pc_q <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            misalign_pc_q <= misalign_pc_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign current_pc  = pc_q;
    assign next_pc     = pc_inc;
    assign fetch_valid = fetch_valid_q;
    assign misalign    = (state_q == ST_FAULT);
    assign misalign_pc = misalign_pc_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen; a second instance with ALIGN_BITS=1 shares all inputs.
module tb_pc_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst, en, redirect_valid, trap_valid, halt_req, resume, fetch_ready;
    logic [31:0] redirect_target, trap_vector;
    logic        fetch_valid, misalign, fetch_valid_a1, misalign_a1;
    logic [31:0] current_pc, next_pc, misalign_pc, current_pc_a1, next_pc_a1, misalign_pc_a1;
    logic [1:0]  state, state_a1;

    int vectors = 0;
    int miscompares = 0;

    always #5 sys_clk = ~sys_clk;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .STEP(4), .ALIGN_BITS(2)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .halt_req(halt_req), .resume(resume),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .current_pc(current_pc), .next_pc(next_pc),
        .misalign(misalign), .misalign_pc(misalign_pc), .state(state)
    );

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .STEP(4), .ALIGN_BITS(1)) u_dut_a1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .halt_req(halt_req), .resume(resume),
        .fetch_valid(fetch_valid_a1), .fetch_ready(fetch_ready),
        .current_pc(current_pc_a1), .next_pc(next_pc_a1),
        .misalign(misalign_a1), .misalign_pc(misalign_pc_a1), .state(state_a1)
    );

    // Advance through one active (falling) edge and settle before sampling.
    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b0; en = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
        trap_valid = 1'b0; trap_vector = '0; halt_req = 1'b0; resume = 1'b0; fetch_ready = 1'b1;
        tick(); tick();
        vectors++;
        if ({state, fetch_valid, misalign} !== {2'd0, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL reset_ctrl: got st=%0d fv=%b mis=%b, want st=0 fv=0 mis=0", state, fetch_valid, misalign);
        end
        vectors++;
        if ({current_pc, next_pc, misalign_pc} !== {32'h0, 32'h4, 32'h0}) begin
            miscompares++; $display("FAIL reset_pc: got pc=%h npc=%h mpc=%h, want 0/4/0", current_pc, next_pc, misalign_pc);
        end
        sys_rst = 1'b1;
        tick();
        vectors++;
        if ({state, fetch_valid, current_pc, next_pc} !== {2'd1, 1'b1, 32'h0, 32'h4}) begin
            miscompares++; $display("FAIL boot_exit: got st=%0d fv=%b pc=%h npc=%h, want 1/1/0/4", state, fetch_valid, current_pc, next_pc);
        end
        tick();
        vectors++;
        if ({current_pc, next_pc} !== {32'h4, 32'h8}) begin
            miscompares++; $display("FAIL seq_4: got pc=%h npc=%h, want 4/8", current_pc, next_pc);
        end
        tick();
        vectors++;
        if ({current_pc, next_pc} !== {32'h8, 32'hC}) begin
            miscompares++; $display("FAIL seq_8: got pc=%h npc=%h, want 8/c", current_pc, next_pc);
        end
    endtask

    task automatic test_backpressure();
        tick(); tick();
        vectors++;
        if (current_pc !== 32'h10) begin
            miscompares++; $display("FAIL bp_start: got pc=%h, want 10", current_pc);
        end
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({fetch_valid, current_pc} !== {1'b1, 32'h10}) begin
                miscompares++; $display("FAIL bp_hold%0d: got fv=%b pc=%h, want 1/10", i, fetch_valid, current_pc);
            end
        end
        fetch_ready = 1'b1;
        tick();
        vectors++;
        if ({current_pc, next_pc} !== {32'h14, 32'h18}) begin
            miscompares++; $display("FAIL bp_release: got pc=%h npc=%h, want 14/18", current_pc, next_pc);
        end
    endtask

    task automatic test_priority();
        redirect_valid = 1'b1; redirect_target = 32'h100; trap_valid = 1'b1; trap_vector = 32'h203;
        tick();
        vectors++;
        if ({state, fetch_valid, current_pc} !== {2'd1, 1'b1, 32'h200}) begin
            miscompares++; $display("FAIL trap_over_redir: got st=%0d fv=%b pc=%h, want 1/1/200", state, fetch_valid, current_pc);
        end
        vectors++;
        if (current_pc_a1 !== 32'h202) begin
            miscompares++; $display("FAIL trap_mask_a1: got pc=%h, want 202", current_pc_a1);
        end
        trap_valid = 1'b0;
        tick();
        vectors++;
        if ({current_pc, next_pc} !== {32'h100, 32'h104}) begin
            miscompares++; $display("FAIL redir_only: got pc=%h npc=%h, want 100/104", current_pc, next_pc);
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_target = 32'h102;
        tick();
        vectors++;
        if ({state, misalign, fetch_valid, current_pc, misalign_pc} !== {2'd3, 1'b1, 1'b0, 32'h100, 32'h102}) begin
            miscompares++; $display("FAIL fault_entry: got st=%0d mis=%b fv=%b pc=%h mpc=%h, want 3/1/0/100/102", state, misalign, fetch_valid, current_pc, misalign_pc);
        end
        vectors++;
        if ({state_a1, misalign_a1, current_pc_a1} !== {2'd1, 1'b0, 32'h102}) begin
            miscompares++; $display("FAIL align1_accept: got st=%0d mis=%b pc=%h, want 1/0/102", state_a1, misalign_a1, current_pc_a1);
        end
        redirect_valid = 1'b0;
        tick();
        vectors++;
        if ({state, misalign, fetch_valid, current_pc} !== {2'd3, 1'b1, 1'b0, 32'h100}) begin
            miscompares++; $display("FAIL fault_hold: got st=%0d mis=%b fv=%b pc=%h, want 3/1/0/100", state, misalign, fetch_valid, current_pc);
        end
        trap_valid = 1'b1; trap_vector = 32'h400;
        tick();
        vectors++;
        if ({state, misalign, fetch_valid, current_pc} !== {2'd1, 1'b0, 1'b1, 32'h400}) begin
            miscompares++; $display("FAIL fault_exit: got st=%0d mis=%b fv=%b pc=%h, want 1/0/1/400", state, misalign, fetch_valid, current_pc);
        end
        trap_valid = 1'b0;
    endtask

    task automatic test_halt_wrap();
        redirect_valid = 1'b1; redirect_target = 32'h20;
        tick();
        redirect_valid = 1'b0; fetch_ready = 1'b0; halt_req = 1'b1;
        tick();
        vectors++;
        if ({state, fetch_valid, current_pc} !== {2'd2, 1'b0, 32'h20}) begin
            miscompares++; $display("FAIL halt_drop: got st=%0d fv=%b pc=%h, want 2/0/20", state, fetch_valid, current_pc);
        end
        halt_req = 1'b0;
        tick();
        vectors++;
        if ({state, current_pc} !== {2'd2, 32'h20}) begin
            miscompares++; $display("FAIL halt_hold: got st=%0d pc=%h, want 2/20", state, current_pc);
        end
        resume = 1'b1;
        tick();
        vectors++;
        if ({state, fetch_valid, current_pc} !== {2'd1, 1'b1, 32'h20}) begin
            miscompares++; $display("FAIL resume: got st=%0d fv=%b pc=%h, want 1/1/20", state, fetch_valid, current_pc);
        end
        resume = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        vectors++;
        if ({current_pc, next_pc} !== {32'hFFFF_FFFC, 32'h0}) begin
            miscompares++; $display("FAIL wrap_npc: got pc=%h npc=%h, want fffffffc/0", current_pc, next_pc);
        end
        redirect_valid = 1'b0;
        tick();
        vectors++;
        if ({current_pc, next_pc} !== {32'h0, 32'h4}) begin
            miscompares++; $display("FAIL wrap_pc: got pc=%h npc=%h, want 0/4", current_pc, next_pc);
        end
        halt_req = 1'b1;
        tick();
        vectors++;
        if ({state, fetch_valid, current_pc} !== {2'd2, 1'b0, 32'h4}) begin
            miscompares++; $display("FAIL halt_accepted: got st=%0d fv=%b pc=%h, want 2/0/4", state, fetch_valid, current_pc);
        end
        halt_req = 1'b0; resume = 1'b1;
        tick();
        resume = 1'b0;
        vectors++;
        if ({state, fetch_valid, current_pc} !== {2'd1, 1'b1, 32'h4}) begin
            miscompares++; $display("FAIL resume2: got st=%0d fv=%b pc=%h, want 1/1/4", state, fetch_valid, current_pc);
        end
    endtask

    task automatic test_reset_mid_en();
        redirect_valid = 1'b1; redirect_target = 32'h102;
        tick();
        vectors++;
        if (state !== 2'd3) begin
            miscompares++; $display("FAIL fault_again: got st=%0d, want 3", state);
        end
        sys_rst = 1'b0;
        tick();
        vectors++;
        if ({state, misalign, fetch_valid, current_pc, misalign_pc} !== {2'd0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            miscompares++; $display("FAIL reset_in_fault: got st=%0d mis=%b fv=%b pc=%h mpc=%h, want 0/0/0/0/0", state, misalign, fetch_valid, current_pc, misalign_pc);
        end
        sys_rst = 1'b1; redirect_valid = 1'b0;
        tick(); tick();
        vectors++;
        if ({state, current_pc} !== {2'd1, 32'h4}) begin
            miscompares++; $display("FAIL rerun: got st=%0d pc=%h, want 1/4", state, current_pc);
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({state, fetch_valid, current_pc, next_pc} !== {2'd1, 1'b1, 32'h4, 32'h8}) begin
                miscompares++; $display("FAIL en_freeze%0d: got st=%0d fv=%b pc=%h npc=%h, want 1/1/4/8", i, state, fetch_valid, current_pc, next_pc);
            end
        end
        en = 1'b1;
        tick();
        vectors++;
        if (current_pc !== 32'h8) begin
            miscompares++; $display("FAIL en_resume: got pc=%h, want 8", current_pc);
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_priority();
        test_misalign();
        test_halt_wrap();
        test_reset_mid_en();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the RISC-V core. Successor to the single-step PC register.
- Drives fetch addresses to instruction memory with a valid/ready handshake.
- Arbitrates trap, branch/jump redirect and sequential advance.
- Detects misaligned redirect targets, and supports halt/resume.

Parameters:
- XLEN, 32, address/PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- STEP, 4, sequential increment in bytes.
- ALIGN_BITS, 2, low target bits that must be zero (1 when compressed instructions are enabled).

Ports:
- sys_clk  in  1  clock; all state updates on the falling edge, as in the rest of the core
- sys_rst  in  1  synchronous, active-low reset
- en  in  1  global advance enable; 0 freezes all state except reset
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  XLEN  ALU-computed target
- trap_valid  in  1  trap/exception entry request
- trap_vector  in  XLEN  trap handler base (mtvec)
- halt_req  in  1  request to stop fetching
- resume  in  1  leave HALT
- fetch_valid  out  1  current_pc is a valid fetch request
- fetch_ready  in  1  imem accepts request
- current_pc  out  XLEN  address being fetched
- next_pc  out  XLEN  current_pc + STEP, for link-register writeback
- misalign  out  1  high while in FAULT
- misalign_pc  out  XLEN  offending target captured on fault
- state  out  2  FSM state, for debug

Behaviour:
- **Reset** (sys_rst==0 at an edge):
  - state=BOOT, current_pc=RESET_VECTOR, next_pc=RESET_VECTOR+STEP.
  - fetch_valid=0, misalign=0, misalign_pc=0.
  - Reset overrides every input, including mid-handshake and in FAULT/HALT.
- **en==0**: all registers hold. Outputs remain stable; fetch_valid keeps its value.
- **FSM states**: BOOT=0, RUN=1, HALT=2, FAULT=3.
  - BOOT: one cycle after reset release with fetch_valid=0, then RUN (fetch_valid=1, current_pc=RESET_VECTOR).
  - RUN: see priority rules below.
  - HALT: fetch_valid=0, PC holds. resume=1 -> RUN with fetch_valid=1 at the held PC. trap_valid=1 -> trap path (has priority over resume).
  - FAULT: fetch_valid=0, misalign=1. Only trap_valid (or reset) exits; trap_valid -> RUN at the trap target, misalign=0.
- **Priority in RUN**, evaluated per edge with en==1, first match wins:
  1. trap_valid: current_pc={trap_vector[XLEN-1:ALIGN_BITS], ALIGN_BITS'b0} (low bits forced to zero, never faults). Stays RUN.
  2. redirect_valid with redirect_target[ALIGN_BITS-1:0]!=0: state=FAULT, misalign_pc=redirect_target, fetch_valid=0. PC unchanged.
  3. redirect_valid, aligned: current_pc=redirect_target.
  4. halt_req: state=HALT, PC holds. An unaccepted request is dropped; an accepted one is completed, so PC advances first if fetch_ready.
  5. fetch_valid&&fetch_ready: current_pc=next_pc.
  6. Otherwise hold. current_pc must remain stable while fetch_valid=1 and fetch_ready=0.
- **Handshake exceptions**:
  - Trap and redirect may replace an unaccepted request; this is the only permitted change of a pending address.
  - A request that was accepted on the same edge as a redirect is considered consumed.
- **next_pc**: always equals current_pc+STEP, updated in the same edge as current_pc.
- **Arithmetic**: modulo 2^XLEN; the increment wraps silently (all-ones region + STEP -> low addresses), with no flag.
- **Latency**: redirect/trap takes effect on the first edge the input is sampled (1 cycle); fetch_valid is asserted in the same cycle as the new PC.

Decomposition:
- Shared core package: state encoding constants (BOOT/RUN/HALT/FAULT) and the default XLEN/RESET_VECTOR/STEP, reused by the decoder and trap unit.
- One sub-module is natural: pc_target_check. It is combinational, taking a target and ALIGN_BITS and producing the misaligned flag and the aligned (low-bits-cleared) value. It is used for both the redirect check and trap_vector masking.

Test Plan:
- **Reset/boot:** sys_rst=0 for 2 edges, then 1, fetch_ready=1 -> 1 cycle fetch_valid=0; then current_pc sequence 0x0,0x4,0x8 with next_pc 0x4,0x8,0xC.
- **Backpressure:** at PC 0x10, hold fetch_ready=0 for 3 cycles -> current_pc stays 0x10 with fetch_valid=1; on release -> 0x14.
- **Redirect/trap priority:** redirect_valid=1 to 0x100 together with trap_valid=1 and trap_vector=0x203 -> current_pc=0x200, state RUN. Next case, redirect alone to 0x100 -> 0x100, next_pc=0x104.
- **Misalignment:** redirect_target=0x102, ALIGN_BITS=2 -> FAULT, misalign=1, misalign_pc=0x102, fetch_valid=0, PC unchanged. Then trap_valid with vector 0x400 -> RUN at 0x400. Repeat with ALIGN_BITS=1 -> 0x102 accepted.
- **Halt/resume and wrap:** halt_req at 0x20 with fetch_ready=0 -> HALT, PC 0x20, fetch_valid=0; resume -> fetch at 0x20. Redirect to 0xFFFF_FFFC, accept -> current_pc=0x0.
- **Reset mid-operation and en:** sys_rst=0 in FAULT -> BOOT, PC=RESET_VECTOR, misalign=0. With en=0 and fetch_ready=1 for 4 cycles -> no PC change.
